// File: rtl/bus_ctrl.sv
// bus_ctrl: CPU-facing bus slave with a RAM region, a small I/O page at
// 0xF0..0xFF (gpio_out, synchronized gpio_in, tick counter, status) and a
// programmable number of wait states before the one-cycle ready pulse.
// Optional feature macro: BUS_TICK_TIMER_EN builds the tick counter at 0xF2;
// without it 0xF2 reads 0x00 and is treated as unmapped.
module bus_ctrl #(
  parameter int RAM_DEPTH   = 240,
  parameter int WAIT_STATES = 1,
  parameter int TICK_DIV    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] RAM_TOP = 8'(RAM_DEPTH);
  localparam logic [3:0] WS_L    = 4'(WAIT_STATES);
  localparam bit         NO_WAIT = (WAIT_STATES == 0);

  // Sticky status update: events win over a same-cycle write-1-to-clear.
  function automatic logic [1:0] w1c_update(input logic [1:0] cur,
                                            input logic [1:0] set,
                                            input logic [1:0] clr);
    return (cur & ~clr) | set;
  endfunction

  state_t      state_r;
  logic [7:0]  addr_r;
  logic [7:0]  wdata_r;
  logic        write_r;
  logic [3:0]  wait_cnt_r;
  logic        ready_r;
  logic [7:0]  rdata_r;
  logic [7:0]  gpio_out_r;
  logic [1:0]  status_r;
  logic [7:0]  gpio_sync1_r;
  logic [7:0]  gpio_sync2_r;
  logic [7:0]  mem_r [RAM_DEPTH];

  logic        strobe_s;
  logic        accept_s;
  logic        busy_strobe_s;
  logic        fire_s;
  logic [7:0]  act_addr_s;
  logic [7:0]  act_wdata_s;
  logic        act_write_s;
  logic [7:0]  rd_val_s;
  logic        unmapped_s;
  logic        ram_we_s;
  logic        gpio_we_s;
  logic [1:0]  clr_s;
  logic [1:0]  set_s;
  logic [1:0]  status_next_s;

`ifdef BUS_TICK_TIMER_EN
  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  logic [PW-1:0] presc_r;
  logic [7:0]    tick_r;

  // Free-running prescaler; tick counter advances once per TICK_DIV clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
      tick_r  <= 8'h00;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= '0;
      tick_r  <= tick_r + 8'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end
`endif

  // Strobe qualification and selection of the operation that completes now.
  // With zero wait states the capture edge is also the commit edge, so the
  // live bus inputs are used; otherwise the latched request is used.
  always_comb begin
    strobe_s      = read | write;
    accept_s      = (state_r == ST_IDLE) && strobe_s;
    busy_strobe_s = (state_r != ST_IDLE) && strobe_s;
    if (state_r == ST_IDLE) begin
      act_addr_s  = address;
      act_wdata_s = wdata;
      act_write_s = write;
    end else begin
      act_addr_s  = addr_r;
      act_wdata_s = wdata_r;
      act_write_s = write_r;
    end
    if (NO_WAIT) begin
      fire_s = accept_s;
    end else begin
      fire_s = (state_r == ST_WAIT) && (wait_cnt_r == 4'd1);
    end
  end

  // Address decode: read value, write enables, unmapped flag, status clears.
  always_comb begin
    rd_val_s   = 8'h00;
    unmapped_s = 1'b0;
    ram_we_s   = 1'b0;
    gpio_we_s  = 1'b0;
    clr_s      = 2'b00;
    if (act_addr_s < RAM_TOP) begin
      ram_we_s = act_write_s;
      rd_val_s = mem_r[act_addr_s];
    end else begin
      case (act_addr_s)
        8'hF0: begin
          gpio_we_s = act_write_s;
          rd_val_s  = gpio_out_r;
        end
        8'hF1: begin
          rd_val_s = gpio_sync2_r;
        end
        8'hF2: begin
`ifdef BUS_TICK_TIMER_EN
          rd_val_s = tick_r;
`else
          unmapped_s = 1'b1;
`endif
        end
        8'hF3: begin
          rd_val_s = {6'b000000, status_r};
          if (act_write_s) begin
            clr_s = act_wdata_s[1:0];
          end else begin
            clr_s = 2'b00;
          end
        end
        default: begin
          unmapped_s = 1'b1;
        end
      endcase
    end
  end

  // Status event/clear combination; clears only take effect on commit.
  always_comb begin
    set_s = {fire_s & unmapped_s, busy_strobe_s};
    if (fire_s) begin
      status_next_s = w1c_update(status_r, set_s, clr_s);
    end else begin
      status_next_s = w1c_update(status_r, set_s, 2'b00);
    end
  end

  // Transaction FSM with registered ready, rdata, gpio_out and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= 8'h00;
      wdata_r    <= 8'h00;
      write_r    <= 1'b0;
      wait_cnt_r <= 4'd0;
      ready_r    <= 1'b0;
      rdata_r    <= 8'h00;
      gpio_out_r <= 8'h00;
      status_r   <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (strobe_s) begin
            addr_r     <= address;
            wdata_r    <= wdata;
            write_r    <= write;
            wait_cnt_r <= WS_L;
            state_r    <= NO_WAIT ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 4'd1) begin
            state_r <= ST_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      ready_r  <= fire_s;
      status_r <= status_next_s;
      if (fire_s && !act_write_s) begin
        rdata_r <= rd_val_s;
      end
      if (fire_s && gpio_we_s) begin
        gpio_out_r <= act_wdata_s;
      end
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && fire_s && ram_we_s) begin
      mem_r[act_addr_s] <= act_wdata_s;
    end
  end

  // Two-flop synchronizer for the asynchronous GPIO inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_sync1_r <= 8'h00;
      gpio_sync2_r <= 8'h00;
    end else begin
      gpio_sync1_r <= gpio_in;
      gpio_sync2_r <= gpio_sync1_r;
    end
  end

  assign rdata    = rdata_r;
  assign ready    = ready_r;
  assign gpio_out = gpio_out_r;

endmodule

// File: tb/tb_bus_ctrl.sv
// Testbench for bus_ctrl: two instances (0 and 1 wait states), a
// transaction-level reference model, a per-cycle compare process and
// directed vectors with literal expectations.
module tb_bus_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] rd_s = 2'b00;
  logic [1:0] wr_s = 2'b00;
  logic [1:0][7:0] ad_s = '0;
  logic [1:0][7:0] wd_s = '0;
  logic [1:0][7:0] gi_s = '0;
  logic [1:0][7:0] rdata_s;
  logic [1:0][7:0] gpio_s;
  logic [1:0]      ready_s;

  int errors = 0;
  int checks = 0;

  bus_ctrl #(.RAM_DEPTH(240), .WAIT_STATES(0), .TICK_DIV(TD)) dut0 (
    .clk(clk), .reset(reset), .read(rd_s[0]), .write(wr_s[0]),
    .address(ad_s[0]), .wdata(wd_s[0]), .rdata(rdata_s[0]),
    .ready(ready_s[0]), .gpio_in(gi_s[0]), .gpio_out(gpio_s[0]));

  bus_ctrl #(.RAM_DEPTH(240), .WAIT_STATES(1), .TICK_DIV(TD)) dut1 (
    .clk(clk), .reset(reset), .read(rd_s[1]), .write(wr_s[1]),
    .address(ad_s[1]), .wdata(wd_s[1]), .rdata(rdata_s[1]),
    .ready(ready_s[1]), .gpio_in(gi_s[1]), .gpio_out(gpio_s[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [2][256];
  logic [7:0] m_gpio [2];
  logic [7:0] m_rdata [2];
  logic [1:0] m_status [2];
  bit         m_ready [2];
  bit         pend [2];
  bit         p_wr [2];
  logic [7:0] p_a [2];
  logic [7:0] p_d [2];
  int         done_at [2];
  int         free_at [2];
  int         e_cnt = 0;
  int         eb;
  logic [1:0] set_v, clr_v;

  // Edge-by-edge transaction model: accept, busy window, commit at done_at.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_cnt = 0;
      for (int d = 0; d < 2; d++) begin
        m_gpio[d] = 8'h00; m_rdata[d] = 8'h00; m_status[d] = 2'b00;
        m_ready[d] = 1'b0; pend[d] = 1'b0; free_at[d] = 0; done_at[d] = 0;
      end
    end else begin
      eb = e_cnt;
      e_cnt = e_cnt + 1;
      for (int d = 0; d < 2; d++) begin
        m_ready[d] = 1'b0;
        set_v = 2'b00;
        clr_v = 2'b00;
        if (rd_s[d] || wr_s[d]) begin
          if (e_cnt < free_at[d]) begin
            set_v[0] = 1'b1;
          end else begin
            pend[d] = 1'b1; p_wr[d] = wr_s[d]; p_a[d] = ad_s[d]; p_d[d] = wd_s[d];
            done_at[d] = e_cnt + d;
            free_at[d] = done_at[d] + 2;
          end
        end
        if (pend[d] && e_cnt == done_at[d]) begin
          pend[d] = 1'b0;
          m_ready[d] = 1'b1;
          if (p_a[d] < 8'd240) begin
            if (p_wr[d]) m_mem[d][p_a[d]] = p_d[d];
            else m_rdata[d] = m_mem[d][p_a[d]];
          end else if (p_a[d] == 8'hF0) begin
            if (p_wr[d]) m_gpio[d] = p_d[d];
            else m_rdata[d] = m_gpio[d];
          end else if (p_a[d] == 8'hF1) begin
            if (!p_wr[d]) m_rdata[d] = gi_s[d];
          end else if (p_a[d] == 8'hF2) begin
`ifdef BUS_TICK_TIMER_EN
            if (!p_wr[d]) m_rdata[d] = 8'((eb / TD) % 256);
`else
            set_v[1] = 1'b1;
            if (!p_wr[d]) m_rdata[d] = 8'h00;
`endif
          end else if (p_a[d] == 8'hF3) begin
            if (p_wr[d]) clr_v = p_d[d][1:0];
            else m_rdata[d] = {6'b000000, m_status[d]};
          end else begin
            set_v[1] = 1'b1;
            if (!p_wr[d]) m_rdata[d] = 8'h00;
          end
        end
        m_status[d] = (m_status[d] & ~clr_v) | set_v;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d ready", d), 32'(ready_s[d]), 32'(m_ready[d]));
        chk($sformatf("dut%0d rdata", d), 32'(rdata_s[d]), 32'(m_rdata[d]));
        chk($sformatf("dut%0d gpio_out", d), 32'(gpio_s[d]), 32'(m_gpio[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input int d, input bit r, input bit w,
                       input logic [7:0] a, input logic [7:0] dv);
    @(negedge clk);
    rd_s[d] = r; wr_s[d] = w; ad_s[d] = a; wd_s[d] = dv;
    @(negedge clk);
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int exp_lat);
    int n = 0;
    while (!ready_s[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready_s[d]) chk($sformatf("dut%0d latency", d), 32'(n + 1), 32'(exp_lat));
    else chk($sformatf("dut%0d ready timeout", d), 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic txn(input int d, input bit r, input bit w,
                     input logic [7:0] a, input logic [7:0] dv);
    pulse(d, r, w, a, dv);
    wait_ready(d, d + 1);
  endtask

  initial begin
    int cnt;
    int c0;
    logic [7:0] v1, v2;
    gi_s[0] = 8'hA5;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset rdata", d), 32'(rdata_s[d]), 32'h00);
      chk($sformatf("dut%0d reset ready", d), 32'(ready_s[d]), 32'h0);
      chk($sformatf("dut%0d reset gpio_out", d), 32'(gpio_s[d]), 32'h00);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // RAM write/read with one wait state.
    txn(1, 1'b0, 1'b1, 8'h10, 8'h5A);
    txn(1, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("ram read 0x10", 32'(rdata_s[1]), 32'h5A);
    repeat (3) @(negedge clk);
    chk("rdata hold", 32'(rdata_s[1]), 32'h5A);

    // GPIO with zero wait states.
    txn(0, 1'b0, 1'b1, 8'hF0, 8'h3C);
    chk("gpio_out write", 32'(gpio_s[0]), 32'h3C);
    txn(0, 1'b1, 1'b0, 8'hF1, 8'h00);
    chk("gpio_in read", 32'(rdata_s[0]), 32'hA5);

    // Unmapped read and status write-1-to-clear.
    txn(0, 1'b1, 1'b0, 8'hF5, 8'h00);
    chk("unmapped read", 32'(rdata_s[0]), 32'h00);
    txn(0, 1'b1, 1'b0, 8'hF3, 8'h00);
    chk("status unmapped", 32'(rdata_s[0]), 32'h02);
    txn(0, 1'b0, 1'b1, 8'hF3, 8'h02);
    txn(0, 1'b1, 1'b0, 8'hF3, 8'h00);
    chk("status cleared", 32'(rdata_s[0]), 32'h00);

    // Second strobe while in WAIT: one ready only, overrun set.
    @(negedge clk);
    rd_s[1] = 1'b1; ad_s[1] = 8'h10;
    @(negedge clk);
    @(negedge clk);
    rd_s[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += 32'(ready_s[1]);
      @(negedge clk);
    end
    chk("overrun single ready", 32'(cnt), 32'd1);
    txn(1, 1'b1, 1'b0, 8'hF3, 8'h00);
    chk("status overrun", 32'(rdata_s[1]), 32'h01);
    txn(1, 1'b0, 1'b1, 8'hF3, 8'h01);

    // Read and write together: write wins, rdata untouched.
    txn(1, 1'b1, 1'b1, 8'h20, 8'h77);
    chk("rd+wr rdata unchanged", 32'(rdata_s[1]), 32'h01);
    txn(1, 1'b1, 1'b0, 8'h20, 8'h00);
    chk("rd+wr ram", 32'(rdata_s[1]), 32'h77);

    // Reset during WAIT aborts the write.
    txn(1, 1'b0, 1'b1, 8'h21, 8'h99);
    txn(1, 1'b0, 1'b1, 8'hF0, 8'h44);
    chk("gpio_out before reset", 32'(gpio_s[1]), 32'h44);
    pulse(1, 1'b0, 1'b1, 8'h21, 8'h11);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cnt += 32'(ready_s[1]);
      @(negedge clk);
    end
    chk("no ready in reset", 32'(cnt), 32'd0);
    chk("gpio_out after reset", 32'(gpio_s[1]), 32'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    txn(1, 1'b1, 1'b0, 8'h21, 8'h00);
    chk("aborted write", 32'(rdata_s[1]), 32'h99);

    // Tick counter: two reads 40 cycles apart.
    c0 = e_cnt;
    txn(1, 1'b1, 1'b0, 8'hF2, 8'h00);
    v1 = rdata_s[1];
    while (e_cnt < c0 + 40) @(negedge clk);
    txn(1, 1'b1, 1'b0, 8'hF2, 8'h00);
    v2 = rdata_s[1];
    txn(1, 1'b1, 1'b0, 8'hF3, 8'h00);
`ifdef BUS_TICK_TIMER_EN
    chk("tick difference", 32'(8'(v2 - v1)), 32'd10);
    chk("tick status", 32'(rdata_s[1]), 32'h00);
`else
    chk("tick absent first", 32'(v1), 32'h00);
    chk("tick absent second", 32'(v2), 32'h00);
    chk("tick absent status", 32'(rdata_s[1]), 32'h02);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
